// File: rtl/imm_encoder.sv
// RV32I immediate encoder: packs an immediate plus register/funct fields
// into an instruction word according to the opcode's format, flags
// immediates that the format cannot represent, and queues the result in a
// small output FIFO. Erroneous requests are counted in a saturating counter.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   in_valid_i/in_ready_o request handshake; accepted when both high
//   opcode_i, imm_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i  request fields
//   out_valid_o/out_ready_i  FIFO head handshake; popped when both high
//   insn_o, err_o         encoded word at head and its error flag
//   err_cnt_o             saturating count of accepted erroneous requests
//
// Build option: define IMM_ENC_STRICT_EN to drop erroneous requests instead
// of queueing them (they are still counted; err_o is then tied low).
module imm_encoder #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [DWIDTH-1:0] imm_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [DWIDTH-1:0] NOP_WORD = DWIDTH'(32'h0000_0013);

  logic [DWIDTH-1:0] enc_word_c;
  logic              enc_err_c;
  logic              fits_i_c;
  logic              fits_b_c;
  logic              fits_j_c;

  // An immediate fits an N-bit signed field when all bits above N-1 copy the sign.
  assign fits_i_c = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fits_b_c = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign fits_j_c = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  // Format-dependent packing and representability check.
  always_comb begin
    enc_word_c = NOP_WORD;
    enc_err_c  = 1'b0;
    case (opcode_i)
      OPC_LUI, OPC_AUIPC: begin
        enc_word_c = {imm_i[31:12], rd_i, opcode_i};
        enc_err_c  = |imm_i[11:0];
      end
      OPC_JAL: begin
        enc_word_c = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        enc_err_c  = imm_i[0] | ~fits_j_c;
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
        enc_word_c = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        enc_err_c  = ~fits_i_c;
      end
      OPC_STORE: begin
        enc_word_c = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        enc_err_c  = ~fits_i_c;
      end
      OPC_BRANCH: begin
        enc_word_c = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                      imm_i[4:1], imm_i[11], opcode_i};
        enc_err_c  = imm_i[0] | ~fits_b_c;
      end
      OPC_OP: begin
        enc_word_c = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        enc_err_c  = 1'b0;
      end
      default: begin
        enc_word_c = NOP_WORD;
        enc_err_c  = 1'b1;
      end
    endcase
  end

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_FW-1:0] count_q;
  logic [CNT_FW-1:0] count_d;
  logic              ready_q;
  logic              valid_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  err_cnt_d;
  logic              accept_c;
  logic              push_c;
  logic              pop_c;

  assign accept_c = in_valid_i & ready_q;
`ifdef IMM_ENC_STRICT_EN
  assign push_c   = accept_c & ~enc_err_c;
`else
  assign push_c   = accept_c;
`endif
  assign pop_c    = valid_q & out_ready_i;

  // Occupancy and saturating error count for the next cycle.
  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
    err_cnt_d = err_cnt_q;
    if (accept_c && enc_err_c && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // FIFO storage and control; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= enc_word_c;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q   <= count_d;
      ready_q   <= (count_d < CNT_FW'(DEPTH));
      valid_q   <= (count_d != '0);
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef IMM_ENC_STRICT_EN
  assign err_o = 1'b0;
`else
  logic err_mem_q [DEPTH];

  // Per-entry error flag, written alongside the word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) err_mem_q[i] <= 1'b0;
    end else if (push_c) begin
      err_mem_q[wr_ptr_q] <= enc_err_c;
    end
  end

  assign err_o = valid_q & err_mem_q[rd_ptr_q];
`endif

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign insn_o      = valid_q ? mem_q[rd_ptr_q] : '0;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed scenarios followed by
// randomized requests checked against a field-level reference model and a
// decode round-trip.
module tb_imm_encoder;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [6:0]  opcode_i;
  logic [31:0] imm_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] insn_o;
  logic        err_o;
  logic [CNT_W-1:0] err_cnt_o;

  imm_encoder #(.DWIDTH(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .opcode_i(opcode_i), .imm_i(imm_i), .rd_i(rd_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .insn_o(insn_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;
  logic [31:0] exp_w_q[$];
  logic        exp_e_q[$];
  logic [31:0] exp_imm_q[$];
  logic [6:0]  exp_op_q[$];

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                           7'h73, 7'h23, 7'h63, 7'h33, 7'h7F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder: field placement per format, range rules on signed integers.
  task automatic ref_enc(input logic [6:0] op, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, output logic [31:0] w, output logic e);
    longint s;
    s = longint'($signed(imm));
    case (op)
      7'h37, 7'h17: begin w = {imm[31:12], rd, op}; e = (imm % 4096) != 0; end
      7'h6F: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        e = (s % 2 != 0) || s < -(64'sd1 <<< 20) || s > (64'sd1 <<< 20) - 2;
      end
      7'h67, 7'h03, 7'h13, 7'h73: begin
        w = {imm[11:0], rs1, f3, rd, op}; e = s < -2048 || s > 2047;
      end
      7'h23: begin
        w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; e = s < -2048 || s > 2047;
      end
      7'h63: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        e = (s % 2 != 0) || s < -4096 || s > 4094;
      end
      7'h33: begin w = {f7, rs2, rs1, f3, rd, op}; e = 1'b0; end
      default: begin w = 32'h0000_0013; e = 1'b1; end
    endcase
  endtask

  // Decoder used to confirm that error-free words carry the original immediate.
  function automatic logic [31:0] dec_imm(input logic [6:0] op, input logic [31:0] w);
    case (op)
      7'h37, 7'h17: dec_imm = {w[31:12], 12'b0};
      7'h6F:        dec_imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      7'h23:        dec_imm = {{20{w[31]}}, w[31:25], w[11:7]};
      7'h63:        dec_imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      default:      dec_imm = {{20{w[31]}}, w[31:20]};
    endcase
  endfunction

  task automatic send(input logic [6:0] op, input logic [31:0] imm,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7);
    logic [31:0] w;
    logic        e;
    int          n;
    opcode_i = op; imm_i = imm; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
    funct3_i = f3; funct7_i = f7; in_valid_i = 1'b1;
    n = 0;
    while (!in_ready_o && n < 50) begin step(); n++; end
    if (!in_ready_o) chk("in_ready_timeout", in_ready_o, 1);
    ref_enc(op, imm, rd, rs1, rs2, f3, f7, w, e);
    step();
    in_valid_i = 1'b0;
    if (e && exp_cnt < 3) exp_cnt++;
`ifdef IMM_ENC_STRICT_EN
    if (!e) begin
`else
    begin
`endif
      exp_w_q.push_back(w); exp_e_q.push_back(e);
      exp_imm_q.push_back(imm); exp_op_q.push_back(op);
    end
    chk("err_cnt_after_req", err_cnt_o, exp_cnt);
  endtask

  task automatic drain();
    while (exp_w_q.size() > 0) begin
      chk("head_valid", out_valid_o, 1);
      chk("head_insn", insn_o, exp_w_q[0]);
      chk("head_err", err_o, exp_e_q[0]);
      if (!exp_e_q[0] && exp_op_q[0] != 7'h33)
        chk("roundtrip_imm", dec_imm(exp_op_q[0], insn_o), exp_imm_q[0]);
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      void'(exp_w_q.pop_front()); void'(exp_e_q.pop_front());
      void'(exp_imm_q.pop_front()); void'(exp_op_q.pop_front());
    end
    chk("empty_after_drain", out_valid_o, 0);
  endtask

  initial begin
    logic [31:0] rimm;
    int          op_idx;
    reset_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    opcode_i = '0; imm_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
    funct3_i = '0; funct7_i = '0;
    step(); step();
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_insn", insn_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);
    chk("rst_in_ready", in_ready_o, 0);
    reset_n = 1'b1;
    step();
    chk("ready_after_rst", in_ready_o, 1);

    // ADDI x1, x0, -1
    send(7'h13, 32'hFFFF_FFFF, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
    chk("addi_valid", out_valid_o, 1);
    chk("addi_insn", insn_o, 32'hFFF0_0093);
    chk("addi_err", err_o, 0);
    drain();

    // LUI, then the same with an unrepresentable low part
    send(7'h37, 32'h1234_5000, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0);
    chk("lui_insn", insn_o, 32'h1234_52B7);
    chk("lui_err", err_o, 0);
    drain();
    send(7'h37, 32'h1234_5001, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0);
`ifndef IMM_ENC_STRICT_EN
    chk("lui_bad_insn", insn_o, 32'h1234_52B7);
    chk("lui_bad_err", err_o, 1);
`endif
    chk("lui_bad_cnt", err_cnt_o, 1);
    drain();

    // JAL and a misaligned branch
    send(7'h6F, 32'h0000_0800, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
    chk("jal_insn", insn_o, 32'h0010_00EF);
    drain();
    send(7'h63, 32'h0000_0003, 5'd0, 5'd2, 5'd3, 3'd1, 7'd0);
`ifndef IMM_ENC_STRICT_EN
    chk("br_bad_err", err_o, 1);
`endif
    chk("br_bad_cnt", err_cnt_o, 2);
    drain();

    // Backpressure: fill, hold a third request, then release
    send(7'h13, 32'h0000_0001, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);  // A = 0x00100093
    send(7'h13, 32'h0000_0002, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0);  // B = 0x00200113
    chk("full_in_ready", in_ready_o, 0);
    opcode_i = 7'h13; imm_i = 32'h0000_0003; rd_i = 5'd3; rs1_i = 5'd0;
    funct3_i = 3'd0; in_valid_i = 1'b1;                        // C = 0x00300193
    step(); step();
    chk("full_hold_ready", in_ready_o, 0);
    out_ready_i = 1'b1;
    chk("bp_head_a", insn_o, 32'h0010_0093);
    step();
    chk("bp_head_b", insn_o, 32'h0020_0113);
    step();
    in_valid_i = 1'b0;
    chk("bp_head_c", insn_o, 32'h0030_0193);
    chk("bp_c_valid", out_valid_o, 1);
    step();
    out_ready_i = 1'b0;
    chk("bp_empty", out_valid_o, 0);
    exp_w_q.delete(); exp_e_q.delete(); exp_imm_q.delete(); exp_op_q.delete();

    // Unknown opcode encodes as NOP
    send(7'h7F, 32'h0000_0000, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0);
`ifndef IMM_ENC_STRICT_EN
    chk("unk_insn", insn_o, 32'h0000_0013);
    chk("unk_err", err_o, 1);
`endif
    chk("unk_cnt", err_cnt_o, 3);
    drain();

    // Reset mid-operation with two queued entries
    send(7'h33, 32'h0, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20);
    send(7'h23, 32'hFFFF_F800, 5'd0, 5'd10, 5'd11, 3'd2, 7'd0);
    chk("pre_rst_valid", out_valid_o, 1);
    chk("pre_rst_full", in_ready_o, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_cnt", err_cnt_o, 0);
    chk("midrst_insn", insn_o, 0);
    chk("midrst_ready", in_ready_o, 0);
    exp_w_q.delete(); exp_e_q.delete(); exp_imm_q.delete(); exp_op_q.delete();
    exp_cnt = 0;
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_ready", in_ready_o, 1);

    // Saturation: five erroneous requests on a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      send(7'h03, 32'h0000_1000 + 32'(k), 5'd1, 5'd2, 5'd0, 3'd2, 7'd0);
      drain();
    end
    chk("sat_cnt", err_cnt_o, 3);

    // Randomized requests
    for (int k = 0; k < 300; k++) begin
      op_idx = int'($urandom_range(0, 10));
      case ($urandom_range(0, 3))
        0: rimm = $urandom;
        1: rimm = 32'($urandom_range(0, 16383)) - 32'd8192;
        2: rimm = $urandom & 32'hFFFF_F000;
        default: rimm = 32'($urandom_range(0, 4095)) - 32'd2048;
      endcase
      if ($urandom_range(0, 1) == 0) rimm = rimm & ~32'h1;
      send(ops[op_idx], rimm, 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 7'($urandom));
      if (exp_w_q.size() >= DEPTH || $urandom_range(0, 2) == 0) drain();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
